// File: rtl/dda_sched_pkg.sv
// Shared types and constants for the dda period scheduler.
package dda_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    LOAD   = 2'd2,
    STROBE = 2'd3
  } sched_state_t;

  localparam int CMD_W   = 8;
  localparam int DIR_BIT = 7;
  localparam int CNT_MSB = 6;
  localparam int CNT_MAX = 127;

  localparam logic [CMD_W-1:0] ZERO_CMD = '0;

  // Builds one axis field; step counts above the field range saturate.
  function automatic logic [CMD_W-1:0] make_cmd(input logic dir, input int unsigned steps);
    logic [CMD_W-1:0] cmd;
    cmd = ZERO_CMD;
    cmd[DIR_BIT] = dir;
    cmd[CNT_MSB:0] = (steps > CNT_MAX) ? 7'(CNT_MAX) : 7'(steps);
    return cmd;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous command FIFO with occupancy output; push when full and pop when
// empty are both ignored, so the pointers never wrap past each other.
module sched_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [4:0]       level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == 5'(DEPTH));
  assign empty   = (level == 5'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Depth is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dda_period_sched.sv
// Per-period dda command scheduler: FIFO-buffered host commands, one load per period.
// Optional UNDERRUN_HOLD_EN: an underrun re-issues the previous dda_n instead of zero.
module dda_period_sched
  import dda_sched_pkg::*;
#(
  parameter int AXES        = 3,
  parameter int PERIOD_CLKS = 20000,
  parameter int FIFO_DEPTH  = 4,
  parameter int WR_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [AXES*CMD_W-1:0] cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [AXES*CMD_W-1:0] dda_n,
  output logic [AXES-1:0]       dda_wr,
  input  logic [AXES-1:0]       dda_busy,
  output logic                  period_tk,
  output logic [4:0]            fifo_level,
  output logic                  underrun,
  output logic                  overrun,
  input  logic                  clr_flags
);

  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD_CLKS - 1);
  localparam logic [2:0]  WR_LAST     = 3'(WR_CYCLES - 1);

  sched_state_t          state;
  sched_state_t          next_state;
  logic [15:0]           period_cnt;
  logic [2:0]            wr_cnt;
  logic                  take;
  logic                  boundary;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [AXES*CMD_W-1:0] head;
  logic [AXES*CMD_W-1:0] underrun_fill;

  sched_fifo #(
    .WIDTH (AXES*CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata (cmd_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign cmd_ready = !fifo_full;
  assign period_tk = (state != IDLE) && (period_cnt == PERIOD_LAST);
  assign boundary  = take && (state == WAIT);
  assign pop       = take && !fifo_empty;

`ifdef UNDERRUN_HOLD_EN
  assign underrun_fill = dda_n;
`else
  assign underrun_fill = {AXES{ZERO_CMD}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // take marks the clock whose edge moves the FIFO head (or the fill value) into dda_n.
  always_comb begin
    next_state = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          next_state = LOAD;
          take       = 1'b1;
        end
      end
      WAIT: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (period_tk) begin
          next_state = LOAD;
          take       = 1'b1;
        end
      end
      LOAD:    next_state = STROBE;
      STROBE: begin
        if (wr_cnt == WR_LAST) next_state = enable ? WAIT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counter sits at zero in IDLE so the first load after enable opens a fresh period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (state == IDLE || period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      dda_wr <= '0;
    end else begin
      wr_cnt <= (state == STROBE) ? wr_cnt + 3'd1 : 3'd0;
      dda_wr <= {AXES{next_state == STROBE}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dda_n <= '0;
    end else if (take) begin
      dda_n <= fifo_empty ? underrun_fill : head;
    end
  end

  // A flag being set on the same clock as clr_flags stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (boundary && fifo_empty) underrun <= 1'b1;
      else if (clr_flags)         underrun <= 1'b0;
      if (boundary && (|dda_busy)) overrun <= 1'b1;
      else if (clr_flags)          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dda_period_sched.sv
// Scoreboard bench for dda_period_sched (PERIOD_CLKS=100, AXES=3, WR_CYCLES=2).
module tb_dda_period_sched;

  localparam int AXES   = 3;
  localparam int PERIOD = 100;
  localparam int DEPTH  = 4;
  localparam int WRC    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [23:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] dda_n;
  logic [2:0]  dda_wr;
  logic [2:0]  dda_busy;
  logic        period_tk;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic        overrun;
  logic        clr_flags;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [23:0] sbq[$];

  dda_period_sched #(
    .AXES        (AXES),
    .PERIOD_CLKS (PERIOD),
    .FIFO_DEPTH  (DEPTH),
    .WR_CYCLES   (WRC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .dda_n      (dda_n),
    .dda_wr     (dda_wr),
    .dda_busy   (dda_busy),
    .period_tk  (period_tk),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .overrun    (overrun),
    .clr_flags  (clr_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic do_reset;
    rst_n = 1'b0; enable = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    clr_flags = 1'b0; dda_busy = '0;
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push_cmd(input logic [23:0] d, input bit expect_accept);
    cmd_data = d; cmd_valid = 1'b1;
    if (expect_accept) sbq.push_back(d);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe(output bit ok, output int at);
    int n = 0;
    ok = 1'b0; at = 0;
    while (dda_wr !== 3'b000 && n < 400) begin @(negedge clk); n++; end
    while (dda_wr !== 3'b111 && n < 400) begin @(negedge clk); n++; end
    if (dda_wr === 3'b111) begin ok = 1'b1; at = cyc; end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (dda_wr !== 3'b000) begin errors++; $display("[TB] FAIL rst_dda_wr got=%b exp=000", dda_wr); end
    checks++; if (dda_n !== 24'h0) begin errors++; $display("[TB] FAIL rst_dda_n got=%h exp=000000", dda_n); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("[TB] FAIL rst_level got=%0d exp=0", fifo_level); end
    checks++; if ({period_tk, underrun, overrun} !== 3'b000) begin
      errors++; $display("[TB] FAIL rst_tk_flags got=%b exp=000", {period_tk, underrun, overrun});
    end
  endtask

  task automatic test_single_load;
    logic [23:0] exp;
    do_reset;
    push_cmd(24'h853200, 1'b1);
    enable = 1'b1;
    @(negedge clk);
    exp = sbq.pop_front();
    checks++; if (dda_n !== exp) begin errors++; $display("[TB] FAIL t1_dda_n got=%h exp=%h", dda_n, exp); end
    checks++; if (dda_wr !== 3'b000) begin errors++; $display("[TB] FAIL t1_setup_wr got=%b exp=000", dda_wr); end
    for (int i = 0; i < WRC; i++) begin
      @(negedge clk);
      checks++; if (dda_wr !== 3'b111) begin errors++; $display("[TB] FAIL t1_wr_high[%0d] got=%b exp=111", i, dda_wr); end
    end
    @(negedge clk);
    checks++; if (dda_wr !== 3'b000) begin errors++; $display("[TB] FAIL t1_wr_low got=%b exp=000", dda_wr); end
    checks++; if ({underrun, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL t1_flags got=%b exp=00", {underrun, overrun}); end
  endtask

  task automatic test_fifo_full_spacing;
    logic [23:0] pats [4] = '{24'h11_22_33, 24'h81_7F_05, 24'h40_C0_0A, 24'hFF_01_80};
    logic [23:0] exp;
    bit ok;
    int at, prev;
    do_reset;
    for (int i = 0; i < 4; i++) push_cmd(pats[i], 1'b1);
    checks++; if (fifo_level !== 5'd4) begin errors++; $display("[TB] FAIL t2_level_full got=%0d exp=4", fifo_level); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL t2_ready_full got=%b exp=0", cmd_ready); end
    push_cmd(24'hDE_AD_77, 1'b0);
    checks++; if (fifo_level !== 5'd4) begin errors++; $display("[TB] FAIL t2_level_after_5th got=%0d exp=4", fifo_level); end
    enable = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(ok, at);
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL t2_strobe_timeout[%0d] got dda_wr=%b exp=111", i, dda_wr);
      end else begin
        exp = sbq.pop_front();
        checks++; if (dda_n !== exp) begin errors++; $display("[TB] FAIL t2_order[%0d] got=%h exp=%h", i, dda_n, exp); end
        if (i > 0) begin
          checks++; if (at - prev != PERIOD) begin errors++; $display("[TB] FAIL t2_spacing[%0d] got=%0d exp=%0d", i, at - prev, PERIOD); end
        end
        prev = at;
      end
    end
    checks++; if ({underrun, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL t2_flags got=%b exp=00", {underrun, overrun}); end
  endtask

  task automatic test_underrun;
    logic [23:0] exp;
    logic [23:0] first = 24'h0C_8D_12;
    bit ok;
    int at, n;
    do_reset;
    push_cmd(first, 1'b1);
    enable = 1'b1;
    wait_strobe(ok, at);
    exp = sbq.pop_front();
    checks++; if (!ok || dda_n !== exp) begin errors++; $display("[TB] FAIL t3_first_load got=%h wr=%b exp=%h", dda_n, dda_wr, exp); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL t3_no_early_underrun got=%b exp=0", underrun); end
`ifdef UNDERRUN_HOLD_EN
    sbq.push_back(first);
`else
    sbq.push_back(24'h000000);
`endif
    wait_strobe(ok, at);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL t3_underrun_strobe_timeout got dda_wr=%b exp=111", dda_wr);
    end else begin
      exp = sbq.pop_front();
      checks++; if (dda_n !== exp) begin errors++; $display("[TB] FAIL t3_underrun_value got=%h exp=%h", dda_n, exp); end
    end
    checks++; if ({underrun, overrun} !== 2'b10) begin errors++; $display("[TB] FAIL t3_flag_set got=%b exp=10", {underrun, overrun}); end
    repeat (3) @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL t3_clear got=%b exp=0", underrun); end
    n = 0;
    while (period_tk !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (period_tk !== 1'b1) begin errors++; $display("[TB] FAIL t3_boundary_timeout got=%b exp=1", period_tk); end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL t3_set_wins got=%b exp=1", underrun); end
  endtask

  task automatic test_overrun;
    logic [23:0] exp;
    bit ok;
    int at;
    do_reset;
    push_cmd(24'h05_06_07, 1'b1);
    push_cmd(24'h87_10_23, 1'b1);
    enable = 1'b1;
    wait_strobe(ok, at);
    exp = sbq.pop_front();
    checks++; if (!ok || dda_n !== exp) begin errors++; $display("[TB] FAIL t4_first_load got=%h exp=%h", dda_n, exp); end
    dda_busy = 3'b010;
    wait_strobe(ok, at);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL t4_busy_strobe_timeout got dda_wr=%b exp=111", dda_wr);
    end else begin
      exp = sbq.pop_front();
      checks++; if (dda_n !== exp) begin errors++; $display("[TB] FAIL t4_busy_load got=%h exp=%h", dda_n, exp); end
    end
    checks++; if ({underrun, overrun} !== 2'b01) begin errors++; $display("[TB] FAIL t4_overrun got=%b exp=01", {underrun, overrun}); end
    dda_busy = 3'b000;
  endtask

  task automatic test_back_to_back;
    logic [23:0] exp;
    logic [23:0] held;
    bit ok;
    int at, bad;
    do_reset;
    push_cmd(24'h21_43_65, 1'b1);
    push_cmd(24'h9A_0B_7C, 1'b1);
    cmd_data = 24'h3C_5D_7E; cmd_valid = 1'b1; sbq.push_back(24'h3C_5D_7E);
    enable = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("[TB] FAIL t5_push_pop_level got=%0d exp=2", fifo_level); end
    wait_strobe(ok, at);
    exp = sbq.pop_front();
    held = exp;
    checks++; if (!ok || dda_n !== exp) begin errors++; $display("[TB] FAIL t5_load got=%h exp=%h", dda_n, exp); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (dda_wr !== 3'b111) begin errors++; $display("[TB] FAIL t5_strobe_completes got=%b exp=111", dda_wr); end
    @(negedge clk);
    checks++; if (dda_wr !== 3'b000) begin errors++; $display("[TB] FAIL t5_strobe_ends got=%b exp=000", dda_wr); end
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (period_tk !== 1'b0 || dda_wr !== 3'b000 || dda_n !== held) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL t5_idle_quiet got=%0d active cycles exp=0", bad); end
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("[TB] FAIL t5_idle_level got=%0d exp=2", fifo_level); end
  endtask

  task automatic test_async_reset;
    bit ok;
    int at;
    do_reset;
    push_cmd(24'h7F_7F_7F, 1'b1);
    push_cmd(24'h01_02_03, 1'b1);
    enable = 1'b1;
    wait_strobe(ok, at);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL t6_strobe_timeout got dda_wr=%b exp=111", dda_wr); end
    rst_n = 1'b0;
    #1;
    checks++; if (dda_wr !== 3'b000) begin errors++; $display("[TB] FAIL t6_wr_drop got=%b exp=000", dda_wr); end
    checks++; if (dda_n !== 24'h0 || fifo_level !== 5'd0 || cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL t6_outputs got n=%h lvl=%0d rdy=%b exp n=000000 lvl=0 rdy=1", dda_n, fifo_level, cmd_ready);
    end
    checks++; if ({period_tk, underrun, overrun} !== 3'b000) begin
      errors++; $display("[TB] FAIL t6_tk_flags got=%b exp=000", {period_tk, underrun, overrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
  endtask

  initial begin
    $display("[TB] dda_period_sched bench start");
    test_reset;
    test_single_load;
    test_fifo_full_spacing;
    test_underrun;
    test_overrun;
    test_back_to_back;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
